// File: rtl/set_bit_iter.sv
// Sequential set-bit iterator: accepts a vector and emits the index of each set
// bit, one per output handshake, lowest-first (MODE=0) or highest-first (MODE=1).

package cf_math_pkg;
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

module set_bit_iter #(
    parameter int WIDTH     = 8,
    parameter bit MODE      = 1'b0,
    parameter int IDX_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [WIDTH-1:0]     vec_i,
    input  logic                 vec_valid_i,
    output logic                 vec_ready_o,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 last_o,
    output logic                 idx_valid_o,
    input  logic                 idx_ready_i,
    output logic                 busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     pending_q, pending_d;

    logic [IDX_WIDTH-1:0] sel_idx;
    logic [WIDTH-1:0]     sel_onehot;
    logic                 single_bit;

    // Priority encoder: the loop direction decides which set bit wins.
    generate
        if (MODE == 1'b0) begin : g_lowest
            always_comb begin
                sel_idx = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (pending_q[i]) sel_idx = IDX_WIDTH'(i);
                end
            end
        end else begin : g_highest
            always_comb begin
                sel_idx = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (pending_q[i]) sel_idx = IDX_WIDTH'(i);
                end
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel_idx == IDX_WIDTH'(gi));
        end
    endgenerate

    assign single_bit = ((pending_q & (pending_q - WIDTH'(1))) == '0);

    // Outputs depend only on registered state and flush_i.
    assign idx_valid_o = (state_q == ITER);
    assign busy_o      = (state_q == ITER);
    assign vec_ready_o = (state_q == IDLE) && !flush_i;
    assign idx_o       = idx_valid_o ? sel_idx : '0;
    assign last_o      = idx_valid_o && single_bit;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (flush_i) begin
            state_d   = IDLE;
            pending_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vec_valid_i && (vec_i != '0)) begin
                        pending_d = vec_i;
                        state_d   = ITER;
                    end
                end
                ITER: begin
                    if (idx_ready_i) begin
                        pending_d = pending_q & ~sel_onehot;
                        if (single_bit) state_d = IDLE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pending_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_set_bit_iter.sv
// Bench for set_bit_iter: directed order/backpressure/flush/reset scenarios on
// WIDTH=8 instances and a randomized queue-model comparison on WIDTH=5 and WIDTH=1.

module tb_set_bit_iter;

    logic       clk = 1'b0;
    logic       rst, flush, vec_valid, idx_ready;
    logic [7:0] vec;

    always #5 clk = ~clk;

    logic       a_vr, a_last, a_iv, a_busy;
    logic [2:0] a_idx;
    logic       d_vr, d_last, d_iv, d_busy;
    logic [2:0] d_idx;
    logic       f_vr, f_last, f_iv, f_busy;
    logic [2:0] f_idx;
    logic       o_vr, o_last, o_iv, o_busy;
    logic [0:0] o_idx;

    int n_chk = 0;
    int n_err = 0;

    set_bit_iter #(.WIDTH(8), .MODE(1'b0)) u_asc8 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .vec_i(vec),
        .vec_valid_i(vec_valid), .vec_ready_o(a_vr), .idx_o(a_idx),
        .last_o(a_last), .idx_valid_o(a_iv), .idx_ready_i(idx_ready), .busy_o(a_busy)
    );

    set_bit_iter #(.WIDTH(8), .MODE(1'b1)) u_desc8 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .vec_i(vec),
        .vec_valid_i(vec_valid), .vec_ready_o(d_vr), .idx_o(d_idx),
        .last_o(d_last), .idx_valid_o(d_iv), .idx_ready_i(idx_ready), .busy_o(d_busy)
    );

    set_bit_iter #(.WIDTH(5), .MODE(1'b1)) u_desc5 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .vec_i(vec[4:0]),
        .vec_valid_i(vec_valid), .vec_ready_o(f_vr), .idx_o(f_idx),
        .last_o(f_last), .idx_valid_o(f_iv), .idx_ready_i(idx_ready), .busy_o(f_busy)
    );

    set_bit_iter #(.WIDTH(1), .MODE(1'b0)) u_asc1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .vec_i(vec[0:0]),
        .vec_valid_i(vec_valid), .vec_ready_o(o_vr), .idx_o(o_idx),
        .last_o(o_last), .idx_valid_o(o_iv), .idx_ready_i(idx_ready), .busy_o(o_busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        rst = 1'b1; flush = 1'b0; vec = '0; vec_valid = 1'b0; idx_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        e = {1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        n_chk++;
        if ({a_vr, a_iv, a_idx, a_last, a_busy} !== e) begin
            n_err++;
            $display("FAIL reset_asc8 got %b want %b", {a_vr, a_iv, a_idx, a_last, a_busy}, e);
        end
        n_chk++;
        if ({d_vr, d_iv, d_idx, d_last, d_busy} !== e) begin
            n_err++;
            $display("FAIL reset_desc8 got %b want %b", {d_vr, d_iv, d_idx, d_last, d_busy}, e);
        end
    endtask

    task automatic test_order();
        logic [2:0] ea [3];
        logic [2:0] ed [3];
        ea = '{3'd2, 3'd5, 3'd7};
        ed = '{3'd7, 3'd5, 3'd2};
        cyc();
        vec = 8'hA4; vec_valid = 1'b1; idx_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({a_vr, d_vr} !== 2'b11) begin
            n_err++;
            $display("FAIL order_ready got %b want 11", {a_vr, d_vr});
        end
        cyc();
        vec_valid = 1'b0; vec = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if ({a_iv, a_idx, a_last} !== {1'b1, ea[k], (k == 2)}) begin
                n_err++;
                $display("FAIL order_asc beat %0d got v=%b idx=%0d last=%b want idx=%0d", k, a_iv, a_idx, a_last, ea[k]);
            end
            n_chk++;
            if ({d_iv, d_idx, d_last} !== {1'b1, ed[k], (k == 2)}) begin
                n_err++;
                $display("FAIL order_desc beat %0d got v=%b idx=%0d last=%b want idx=%0d", k, d_iv, d_idx, d_last, ed[k]);
            end
            cyc();
        end
        @(negedge clk);
        n_chk++;
        if ({a_vr, a_iv, d_vr, d_iv} !== 4'b1010) begin
            n_err++;
            $display("FAIL order_return got %b want 1010", {a_vr, a_iv, d_vr, d_iv});
        end
    endtask

    task automatic test_backpressure();
        cyc();
        vec = 8'h81; vec_valid = 1'b1; idx_ready = 1'b0;
        cyc();
        vec_valid = 1'b0; vec = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if ({a_iv, a_idx, a_last} !== {1'b1, 3'd0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold cyc %0d got v=%b idx=%0d last=%b want v=1 idx=0 last=0", k, a_iv, a_idx, a_last);
            end
            cyc();
        end
        idx_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({a_iv, a_idx, a_last} !== {1'b1, 3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL bp_first got v=%b idx=%0d last=%b want 1/0/0", a_iv, a_idx, a_last);
        end
        cyc();
        @(negedge clk);
        n_chk++;
        if ({a_iv, a_idx, a_last} !== {1'b1, 3'd7, 1'b1}) begin
            n_err++;
            $display("FAIL bp_second got v=%b idx=%0d last=%b want 1/7/1", a_iv, a_idx, a_last);
        end
        cyc();
        @(negedge clk);
        n_chk++;
        if ({a_vr, a_iv} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_done got %b want 10", {a_vr, a_iv});
        end
    endtask

    task automatic test_zero_full();
        cyc();
        vec = 8'h00; vec_valid = 1'b1; idx_ready = 1'b1;
        cyc();
        vec_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({a_vr, a_iv, a_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL zero_vec got vr/iv/busy=%b want 100", {a_vr, a_iv, a_busy});
        end
        cyc();
        vec = 8'hFF; vec_valid = 1'b1;
        cyc();
        vec_valid = 1'b0; vec = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_chk++;
            if ({a_iv, a_idx, a_last} !== {1'b1, 3'(k), (k == 7)}) begin
                n_err++;
                $display("FAIL full_beat %0d got v=%b idx=%0d last=%b want idx=%0d", k, a_iv, a_idx, a_last, k);
            end
            cyc();
        end
        @(negedge clk);
        n_chk++;
        if ({a_vr, a_iv, a_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL full_done got %b want 100", {a_vr, a_iv, a_busy});
        end
    endtask

    task automatic test_flush();
        cyc();
        vec = 8'hF0; vec_valid = 1'b1; idx_ready = 1'b1;
        cyc();
        vec_valid = 1'b0; vec = '0;
        @(negedge clk);
        n_chk++;
        if ({a_iv, a_idx, a_last} !== {1'b1, 3'd4, 1'b0}) begin
            n_err++;
            $display("FAIL flush_first got v=%b idx=%0d last=%b want 1/4/0", a_iv, a_idx, a_last);
        end
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({a_vr, a_iv, a_idx, a_last, a_busy} !== 7'b1000000) begin
            n_err++;
            $display("FAIL flush_mid got %b want 1000000", {a_vr, a_iv, a_idx, a_last, a_busy});
        end
        // A vector offered during flush must be refused and ignored.
        cyc();
        flush = 1'b1; vec = 8'hF0; vec_valid = 1'b1;
        @(negedge clk);
        n_chk++;
        if (a_vr !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready got %b want 0", a_vr);
        end
        cyc();
        flush = 1'b0; vec_valid = 1'b0; vec = '0;
        @(negedge clk);
        n_chk++;
        if ({a_iv, a_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_idle_vec got %b want 00", {a_iv, a_busy});
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        vec = 8'hF0; vec_valid = 1'b1; idx_ready = 1'b1;
        cyc();
        vec_valid = 1'b0; vec = '0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({a_vr, a_iv, a_idx, a_last, a_busy} !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_mid got %b want 1000000", {a_vr, a_iv, a_idx, a_last, a_busy});
        end
    endtask

    task automatic test_random();
        int         q5[$];
        int         q1[$];
        logic [6:0] e5, g5;
        logic [4:0] e1, g1;
        logic       iv;
        rst = 1'b1; flush = 1'b0; vec_valid = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            cyc();
            rst       = 1'b0;
            vec_valid = ($urandom_range(0, 1) == 1);
            vec       = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            idx_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 29) == 0);
            @(negedge clk);

            iv = (q5.size() != 0);
            e5 = {(!iv && !flush), iv, (iv ? 3'(q5[0]) : 3'd0), (q5.size() == 1), iv};
            g5 = {f_vr, f_iv, f_idx, f_last, f_busy};
            n_chk++;
            if (g5 !== e5) begin
                n_err++;
                $display("FAIL rand_w5 cyc %0d got %b want %b", c, g5, e5);
            end
            iv = (q1.size() != 0);
            e1 = {(!iv && !flush), iv, 1'b0, (q1.size() == 1), iv};
            g1 = {o_vr, o_iv, o_idx, o_last, o_busy};
            n_chk++;
            if (g1 !== e1) begin
                n_err++;
                $display("FAIL rand_w1 cyc %0d got %b want %b", c, g1, e1);
            end

            // Model: a vector becomes the list of its set-bit indices, drained in order.
            if (flush) begin
                q5.delete();
                q1.delete();
            end else begin
                if (q5.size() != 0) begin
                    if (idx_ready) void'(q5.pop_front());
                end else if (vec_valid) begin
                    for (int i = 4; i >= 0; i--) if (vec[i]) q5.push_back(i);
                end
                if (q1.size() != 0) begin
                    if (idx_ready) void'(q1.pop_front());
                end else if (vec_valid && vec[0]) begin
                    q1.push_back(0);
                end
            end
        end
        cyc();
        flush = 1'b0; vec_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_order();
        test_backpressure();
        test_zero_full();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/set_bit_iter.md
# set_bit_iter

Sequential set-bit iterator. It accepts a bit vector over a valid/ready handshake and emits the index of every set bit, one index per accepted output beat, in ascending or descending order. Internally it applies trailing/leading zero counting to a shrinking pending mask. Typical uses are draining a request mask into an arbiter or allocator, or walking dirty/valid bitmaps one entry at a time.

## Interface
- `WIDTH`, default 8: width of the input vector; must be ≥ 1.
- `MODE`, default 1'b0: iteration order. 0 = lowest index first (trailing-zero order). 1 = highest index first (leading-zero order; the emitted value is still the absolute bit index).
- `IDX_WIDTH`, default `cf_math_pkg::idx_width(WIDTH)`: dependent parameter, do not override.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  synchronous clear of any iteration in progress.
- `vec_i`  in  WIDTH  input vector.
- `vec_valid_i`  in  1  input vector valid.
- `vec_ready_o`  out  1  block can accept a vector.
- `idx_o`  out  IDX_WIDTH  index of the current set bit.
- `last_o`  out  1  current index is the final set bit of the vector.
- `idx_valid_o`  out  1  `idx_o` and `last_o` are valid.
- `idx_ready_i`  in  1  consumer accepts the index.
- `busy_o`  out  1  an iteration is in progress.

## Operation
- State: a 1-bit FSM (IDLE, ITER) and a WIDTH-bit `pending` register.
- IDLE:
  - `vec_ready_o`=1, `idx_valid_o`=0.
  - On `vec_valid_i` with nonzero `vec_i`: `pending` ← `vec_i`, go to ITER.
  - On `vec_valid_i` with `vec_i`=0: the vector is consumed and dropped; no beat is emitted and the FSM stays in IDLE.
- ITER:
  - `vec_ready_o`=0, `idx_valid_o`=1, `busy_o`=1.
  - `idx_o` is the lowest set index of `pending` (MODE 0) or the highest (MODE 1).
  - `last_o`=1 exactly when `pending` has a single bit set.
- Output handshake (`idx_valid_o` & `idx_ready_i`): clear bit `idx_o` in `pending`. If `last_o`=1, go to IDLE.
- When `idx_valid_o`=0, `idx_o` and `last_o` are driven to 0.
- `flush_i`, in any state: `pending` ← 0, go to IDLE. A handshake in the same cycle counts as taken by the consumer, but no further beats follow. A vector offered in the same cycle is not accepted (`vec_ready_o` is masked to 0 while `flush_i`=1).
- `rst_i` has priority over `flush_i`; both have priority over handshakes.
- WIDTH=1: `idx_o` is always 0 and every accepted nonzero vector emits a single beat with `last_o`=1.
- No combinational path from `idx_ready_i` to `vec_ready_o`, or from `vec_valid_i` to `idx_valid_o`. `vec_ready_o` depends on `flush_i` only.

## Timing
- Reset values (the cycle after `rst_i` is sampled high): IDLE, `pending`=0, `vec_ready_o`=1, `idx_valid_o`=0, `idx_o`=0, `last_o`=0, `busy_o`=0.
- Vector accepted in cycle N → first beat has `idx_valid_o`=1 in cycle N+1.
- Each output handshake advances by one index per cycle, so a vector with k set bits drains in k cycles under no backpressure.
- Last handshake in cycle M → `vec_ready_o`=1 in cycle M+1 (one-cycle bubble between vectors). Steady-state throughput is k+1 cycles per vector.
- Stability under backpressure: while `idx_valid_o`=1 and `idx_ready_i`=0, `idx_o` and `last_o` hold stable and `idx_valid_o` does not deassert, except on `flush_i` or `rst_i`.
- Reset or flush mid-iteration: `idx_valid_o`=0 in the following cycle; any remaining bits are discarded.

## Test plan
- Ascending order: WIDTH=8, MODE=0, `vec_i`=8'b1010_0100, `idx_ready_i`=1 → `idx_o`=2, 5, 7 in cycles N+1..N+3, `last_o` asserted only with 7; `vec_ready_o` returns at N+4.
- Descending order: MODE=1, same vector → `idx_o`=7, 5, 2, `last_o` asserted only with 2.
- Backpressure: `vec_i`=8'h81, `idx_ready_i` low for 3 cycles → `idx_o`=0 held stable with `idx_valid_o`=1 for all 3 cycles; then 0 followed by 7 (last), with no lost or duplicated beat.
- Zero and full vectors: `vec_i`=0 → accepted, no beat emitted, `busy_o` stays 0. Then `vec_i`=8'hFF → 8 beats, indices 0..7, `last_o` on 7.
- Flush and reset mid-stream: `vec_i`=8'hF0, pulse `flush_i` after the first beat (index 4) → `idx_valid_o`=0 the next cycle and IDLE. Repeat with `rst_i` instead of `flush_i` → all outputs at reset values the next cycle.
- Randomized stream (WIDTH=5 and WIDTH=1, random valid/ready) vs. a scoreboard model → emitted index sequence matches the set bits in the order required by MODE, with exactly one `last_o` per nonzero vector.
